shift_reg_serdes: RTL and testbench
===================================

Name: shift_reg_serdes

Overview:
- Single-clock model of a paired 74xx-style parallel-in/serial-out and serial-in/parallel-out shift register, as used on the isolator board for slot control lines (dir/chan, hwflag, cs_n, hwcon).
- A common strobe `srclk` loads the transmit register from a parallel word and latches the receive register to a parallel output.
- It sits between the host serial link (one bit per `sclk`) and per-slot parallel control/status bits.

Parameters:
- WIDTH, 8, parallel word width; both shift registers have this width; legal range 2..32.
- LAUNCH_NEGEDGE, 0, 0 = ser_out changes after the rising edge; 1 = ser_out re-registered on the falling edge of sclk.

Ports:
- sclk  input  1  shift clock; all state updates on the rising edge unless noted.
- reset_n  input  1  asynchronous active-low reset.
- srclk  input  1  parallel strobe, synchronous to sclk; acts on its rising transition.
- par_in  input  WIDTH  word loaded into the transmit register.
- ser_out  output  1  transmit serial data, MSB first.
- ser_in  input  1  receive serial data, MSB first.
- par_out  output  WIDTH  last latched receive word.
- par_valid  output  1  one-cycle pulse when par_out updates.
- fifo_rd_en  input  1  capture-FIFO pop (optional feature).
- fifo_rd_data  output  WIDTH  capture-FIFO head word.
- fifo_empty  output  1  capture FIFO empty.
- fifo_full  output  1  capture FIFO full.
- fifo_overflow  output  1  sticky: a capture was dropped.

Behaviour:
- Reset (async, reset_n=0):
  - tx_sh, rx_sh, par_out, srclk_q, FIFO pointers and count all cleared.
  - par_valid=0, ser_out=0, fifo_overflow=0, fifo_empty=1, fifo_full=0.
  - Reset asserted mid-word discards all partial data.
  - Operation resumes on the first rising sclk edge after release.
- Strobe detect: srclk_q <= srclk each edge; rise = srclk & ~srclk_q. A level held high causes exactly one load/capture.
- Transmit, each rising edge:
  - If rise, tx_sh <= par_in. Load has priority over shift.
  - Otherwise tx_sh <= {tx_sh[WIDTH-2:0], 0}.
- ser_out:
  - LAUNCH_NEGEDGE=0: ser_out = tx_sh[WIDTH-1] combinationally, so bit 7 is visible right after the load edge.
  - LAUNCH_NEGEDGE=1: ser_out is a register loaded from tx_sh[WIDTH-1] on each falling sclk edge (half-cycle later); reset 0.
- Receive, each rising edge: rx_sh <= {rx_sh[WIDTH-2:0], ser_in}.
- Capture:
  - If rise, par_out <= {rx_sh[WIDTH-2:0], ser_in}, i.e. the word includes the bit sampled on the strobe edge.
  - par_valid=1 for exactly that following cycle.
  - par_out otherwise holds.
- Simultaneous: the same rise both loads tx and captures rx.
- Loopback (ser_out->ser_in, LAUNCH_NEGEDGE=0) with srclk rising every WIDTH cycles returns par_in on par_out one strobe later.
- No overrun/underrun state: shifting beyond WIDTH bits feeds zeros out and discards the oldest rx bits.

Optional Feature:
- Macro SHIFT_REG_SERDES_CAPTURE_FIFO_EN.
- Defined: 4-entry FIFO written with each captured word in the same edge par_out updates.
  - fifo_rd_data shows the head (first-word-fall-through).
  - fifo_rd_en pops when not empty; pop while empty is ignored.
  - Simultaneous push and pop is allowed when not empty.
  - Push while full (with no pop) drops the new word and sets fifo_overflow; fifo_overflow clears only on reset.
- Not defined: ports remain; fifo_rd_data=0, fifo_empty=1, fifo_full=0, fifo_overflow=0, fifo_rd_en ignored.

Test Plan:
1. Reset: load par_in=8'hFF and shift 3 cycles, assert reset_n=0 asynchronously -> ser_out, par_out, par_valid drop to 0 immediately without a clock edge.
2. Transmit: par_in=8'hA5, srclk rise at edge 0 (LAUNCH_NEGEDGE=0) -> ser_out after edges 0..7 = 1,0,1,0,0,1,0,1, then 0s.
3. Receive: ser_in=1,1,0,0,1,0,1,0 on edges 1..8, srclk rise at edge 8 -> par_out=8'hCA, par_valid high for one cycle only.
4. Held strobe: srclk high for 5 cycles -> single load and single par_valid pulse; tx continues shifting from cycle 2.
5. Loopback: ser_out tied to ser_in, srclk rises every 8 cycles with par_in=8'h3C then 8'h81 -> par_out=8'h3C at second strobe, 8'h81 at third.
6. FIFO (macro defined): 5 captures 8'h01..8'h05, no reads -> fifo_full after 4th, fifo_overflow=1 after 5th; 4 pops return 01,02,03,04, then fifo_empty=1.

Source files
------------

// File: rtl/shift_reg_serdes.sv
// shift_reg_serdes: paired parallel-in/serial-out and serial-in/parallel-out
// shift registers sharing one parallel strobe (srclk), clocked by sclk.
// Optional 4-entry capture FIFO behind SHIFT_REG_SERDES_CAPTURE_FIFO_EN;
// with the macro undefined the FIFO ports are tied to their idle values.
`timescale 1ns/1ps
module shift_reg_serdes #(
  parameter int WIDTH          = 8,
  parameter bit LAUNCH_NEGEDGE = 1'b0
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic             srclk,
  input  logic [WIDTH-1:0] par_in,
  output logic             ser_out,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             fifo_rd_en,
  output logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             fifo_overflow
);

  logic             srclk_q;
  logic             rise;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] rx_sh;
  logic [WIDTH-1:0] rx_word;

  // A held-high strobe yields a single rise, hence one load/capture.
  assign rise    = srclk & ~srclk_q;
  // Captured word includes the bit sampled on the strobe edge itself.
  assign rx_word = {rx_sh[WIDTH-2:0], ser_in};

  // Strobe history for rising-transition detect.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) srclk_q <= 1'b0;
    else          srclk_q <= srclk;
  end

  // Transmit register: load wins over shift; zeros fill from the LSB.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n)  tx_sh <= '0;
    else if (rise) tx_sh <= par_in;
    else           tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
  end

  // Receive register shifts every edge; the oldest bit falls off the top.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) rx_sh <= '0;
    else          rx_sh <= rx_word;
  end

  // Parallel latch and its one-cycle valid pulse.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      par_out   <= '0;
      par_valid <= 1'b0;
    end else begin
      par_valid <= rise;
      if (rise) par_out <= rx_word;
    end
  end

  generate
    if (LAUNCH_NEGEDGE) begin : g_launch_neg
      logic ser_q;
      // Half-cycle relaunch gives the far end a full half period of hold.
      always_ff @(negedge sclk or negedge reset_n) begin
        if (!reset_n) ser_q <= 1'b0;
        else          ser_q <= tx_sh[WIDTH-1];
      end
      assign ser_out = ser_q;
    end else begin : g_launch_pos
      assign ser_out = tx_sh[WIDTH-1];
    end
  endgenerate

`ifdef SHIFT_REG_SERDES_CAPTURE_FIFO_EN
  localparam int DEPTH = 4;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [1:0]                  wptr;
  logic [1:0]                  rptr;
  logic [2:0]                  cnt;
  logic                        pop;
  logic                        wr;
  logic                        ovf;

  // Pop while empty is ignored; a full FIFO still accepts a push when the
  // same edge pops, since a slot frees up.
  assign pop = fifo_rd_en & (cnt != 3'd0);
  assign wr  = rise & ((cnt != 3'(DEPTH)) | pop);

  // Pointer, count and sticky overflow bookkeeping.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 2'd1;
      if (pop) rptr <= rptr + 2'd1;
      cnt <= cnt + {2'b00, wr} - {2'b00, pop};
      if (rise && !wr) ovf <= 1'b1;
    end
  end

  // Storage needs no reset; the count guards what is visible.
  always_ff @(posedge sclk) begin
    if (wr) mem[wptr] <= rx_word;
  end

  assign fifo_rd_data  = mem[rptr];
  assign fifo_empty    = (cnt == 3'd0);
  assign fifo_full     = (cnt == 3'(DEPTH));
  assign fifo_overflow = ovf;
`else
  logic fifo_rd_en_unused;
  assign fifo_rd_en_unused = fifo_rd_en;

  assign fifo_rd_data  = '0;
  assign fifo_empty    = 1'b1;
  assign fifo_full     = 1'b0;
  assign fifo_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_serdes.sv
// Directed bench for shift_reg_serdes (WIDTH=8, LAUNCH_NEGEDGE=0).
// Captures are scoreboarded: the expected word is queued as the strobe is
// driven and popped when par_valid appears. FIFO section follows
// SHIFT_REG_SERDES_CAPTURE_FIFO_EN.
`timescale 1ns/1ps
module tb_shift_reg_serdes;
  localparam int W = 8;

  logic         sclk = 1'b0;
  logic         reset_n = 1'b0;
  logic         srclk = 1'b0;
  logic [W-1:0] par_in = '0;
  logic         ser_in = 1'b0;
  logic         fifo_rd_en = 1'b0;
  logic         ser_out;
  logic [W-1:0] par_out;
  logic         par_valid;
  logic [W-1:0] fifo_rd_data;
  logic         fifo_empty;
  logic         fifo_full;
  logic         fifo_overflow;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_rx = '0;
  logic         m_srq = 1'b0;
  bit           loopback = 1'b0;

  shift_reg_serdes #(.WIDTH(W), .LAUNCH_NEGEDGE(1'b0)) dut (
    .sclk(sclk), .reset_n(reset_n), .srclk(srclk), .par_in(par_in),
    .ser_out(ser_out), .ser_in(ser_in), .par_out(par_out),
    .par_valid(par_valid), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_overflow(fifo_overflow)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One rising sclk edge with the inputs currently driven; queues the
  // capture expected on a strobe rise and checks it after the edge.
  task automatic step();
    logic         rise;
    logic [W-1:0] e;
    if (loopback) ser_in = ser_out;
    rise  = srclk & ~m_srq;
    m_rx  = {m_rx[W-2:0], ser_in};
    m_srq = srclk;
    if (rise) exp_q.push_back(m_rx);
    @(posedge sclk); #1;
    chk("par_valid", 32'(par_valid), 32'(rise));
    if (rise) begin
      e = exp_q.pop_front();
      chk("par_out", 32'(par_out), 32'(e));
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs checked before
  // any further edge.
  task automatic do_reset();
    @(negedge sclk); #2;
    reset_n = 1'b0; #1;
    chk("rst_ser_out", 32'(ser_out), 32'd0);
    chk("rst_par_out", 32'(par_out), 32'd0);
    chk("rst_par_valid", 32'(par_valid), 32'd0);
    chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    chk("rst_fifo_full", 32'(fifo_full), 32'd0);
    chk("rst_fifo_overflow", 32'(fifo_overflow), 32'd0);
    srclk = 1'b0; ser_in = 1'b0; fifo_rd_en = 1'b0;
    m_rx = '0; m_srq = 1'b0; exp_q.delete();
    @(negedge sclk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] pat;
    logic [W-1:0] sh;
    logic [W-1:0] wd;
    logic [W-1:0] fq[$];
    logic [W-1:0] words[3];

    do_reset();

    // 1: load FF, shift 3, capture a nonzero word, then reset mid-cycle.
    par_in = 8'hFF; ser_in = 1'b1; srclk = 1'b1; step();
    srclk = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t1_ser_out", 32'(ser_out), 32'd1);
    srclk = 1'b1; step();
    chk("t1_par_out_1f", 32'(par_out), 32'h1F);
    do_reset();

    // 2: transmit A5 MSB first, then zeros.
    srclk = 1'b0; step();
    pat = 8'hA5; par_in = pat; srclk = 1'b1; step();
    chk("t2_bit7", 32'(ser_out), 32'(pat[7]));
    srclk = 1'b0;
    for (int k = 1; k < 8; k++) begin
      step();
      chk("t2_bit", 32'(ser_out), 32'(pat[7-k]));
    end
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t2_zero", 32'(ser_out), 32'd0);
    end

    // 3: receive 1,1,0,0,1,0,1,0 with strobe on the last bit.
    pat = 8'hCA;
    for (int i = 0; i < 8; i++) begin
      ser_in = pat[7-i]; srclk = (i == 7); step();
    end
    chk("t3_par_out", 32'(par_out), 32'hCA);
    srclk = 1'b0; ser_in = 1'b0; step();
    chk("t3_hold", 32'(par_out), 32'hCA);

    // 4: strobe held high for 5 cycles: one load, shifting from cycle 2.
    par_in = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      srclk = 1'b1; step();
      sh = 8'hC3 << i;
      chk("t4_ser_out", 32'(ser_out), 32'(sh[7]));
    end
    srclk = 1'b0; step();

    // 5: loopback with strobe every 8 cycles.
    loopback = 1'b1;
    words[0] = 8'h3C; words[1] = 8'h81; words[2] = 8'h00;
    for (int s = 0; s < 3; s++) begin
      par_in = words[s]; srclk = 1'b1; step();
      if (s > 0) chk("t5_loopback", 32'(par_out), 32'(words[s-1]));
      srclk = 1'b0;
      for (int i = 0; i < 7; i++) step();
    end
    loopback = 1'b0;

`ifdef SHIFT_REG_SERDES_CAPTURE_FIFO_EN
    // 6: five captures into a 4-deep FIFO, then drain.
    do_reset();
    for (int w = 1; w <= 5; w++) begin
      wd = W'(w);
      for (int i = 0; i < 8; i++) begin
        ser_in = wd[7-i]; srclk = (i == 7); step();
      end
      if (fq.size() < 4) fq.push_back(wd);
      chk("t6_full", 32'(fifo_full), 32'(fq.size() == 4));
      chk("t6_empty", 32'(fifo_empty), 32'd0);
      chk("t6_overflow", 32'(fifo_overflow), 32'(w == 5));
    end
    srclk = 1'b0; ser_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_rd_data", 32'(fifo_rd_data), 32'(fq[0]));
      fifo_rd_en = 1'b1; step();
      fifo_rd_en = 1'b0;
      void'(fq.pop_front());
    end
    chk("t6_drained", 32'(fifo_empty), 32'd1);
    fifo_rd_en = 1'b1; step(); fifo_rd_en = 1'b0;
    chk("t6_pop_empty", 32'(fifo_empty), 32'd1);
    chk("t6_full_after", 32'(fifo_full), 32'd0);
    chk("t6_ovf_sticky", 32'(fifo_overflow), 32'd1);
`else
    // 6: FIFO compiled out: ports sit idle regardless of fifo_rd_en.
    fifo_rd_en = 1'b1; step(); fifo_rd_en = 1'b0;
    chk("t6_rd_data_off", 32'(fifo_rd_data), 32'd0);
    chk("t6_empty_off", 32'(fifo_empty), 32'd1);
    chk("t6_full_off", 32'(fifo_full), 32'd0);
    chk("t6_ovf_off", 32'(fifo_overflow), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
